// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared driver FSM state type and default pipeline geometry
package pipeline_pkg;
  localparam int PIPE_LATENCY = 5;
  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_FIFO_DEPTH = 8;
  typedef enum logic [1:0] {RUN, FLUSH, DRAIN} drv_state_t;
endpackage

// File: rtl/pipeline_result_fifo.sv
// pipeline_result_fifo: synchronous result FIFO with occupancy count; head reads 0 when empty
module pipeline_result_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && count != '0;
  assign do_push = push && !full;
  assign head = count != '0 ? mem[rd_ptr] : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/pipeline_driver.sv
// pipeline_driver: credit-gated issue/capture controller for pipeline_unit.
// Define PIPE_DRIVER_CHECK_EN to add the sticky proto_err output.
module pipeline_driver
  import pipeline_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int LATENCY = PIPE_LATENCY,
  parameter int FIFO_DEPTH = PIPE_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] req_data,
  input  logic              req_valid,
  output logic              req_ready,
  output logic [DATA_W-1:0] pipe_inputs,
  output logic              pipe_in_valid,
  output logic              pipe_flush,
  input  logic [DATA_W-1:0] pipe_outputs,
  input  logic              pipe_out_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  input  logic              flush_req,
  output logic              busy
`ifdef PIPE_DRIVER_CHECK_EN
  ,
  output logic              proto_err
`endif
);
  localparam int IW = $clog2(LATENCY + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(FIFO_DEPTH + LATENCY + 1);
  localparam int DW = $clog2(LATENCY + 1);
  drv_state_t state, state_nx;
  logic [DW-1:0] drain_cnt, drain_cnt_nx;
  logic [LATENCY-1:0] slots;
  logic [IW-1:0] inflight;
  logic [CW-1:0] fifo_count;
  logic [SW-1:0] credit_used;
  logic fifo_full, issue, tap, capture;
  // every issued slot reserves a FIFO entry until it is popped, so the FIFO cannot overflow
  assign credit_used = SW'(inflight) + SW'(fifo_count);
  assign tap = slots[LATENCY-1];
  assign capture = tap && state == RUN;
  assign req_ready = state == RUN && !flush_req && credit_used < SW'(FIFO_DEPTH);
  assign issue = req_valid && req_ready;
  assign pipe_in_valid = issue;
  assign pipe_inputs = issue ? req_data : '0;
  assign pipe_flush = state == FLUSH;
  assign busy = inflight != '0 || state != RUN;
  assign rsp_valid = fifo_count != '0;
  always_comb begin
    state_nx = state == RUN ? (flush_req ? FLUSH : RUN) :
               state == FLUSH ? DRAIN : (drain_cnt == '0 ? RUN : DRAIN);
    drain_cnt_nx = state == FLUSH ? DW'(LATENCY - 1) :
                   state == DRAIN ? drain_cnt - DW'(1) : drain_cnt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      drain_cnt <= '0;
    end else begin
      state <= state_nx;
      drain_cnt <= drain_cnt_nx;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || state == FLUSH) begin
      slots <= '0;
      inflight <= '0;
    end else begin
      slots <= LATENCY'({slots, issue});
      inflight <= inflight + IW'(issue) - IW'(capture);
    end
  end
  pipeline_result_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(capture),
    .push_data(pipe_outputs),
    .pop(rsp_ready),
    .head(rsp_data),
    .count(fifo_count),
    .full(fifo_full)
  );
`ifdef PIPE_DRIVER_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) proto_err <= 1'b0;
    else if (capture && (!pipe_out_valid || fifo_full)) proto_err <= 1'b1;
  end
`else
  logic unused_chk;
  assign unused_chk = &{1'b0, pipe_out_valid, fifo_full};
`endif
endmodule

// File: tb/tb_pipeline_driver.sv
// tb_pipeline_driver: directed bench with a stand-in 5-stage pipeline_unit model
module tb_pipeline_driver;
  logic clk = 0;
  logic reset = 1;
  logic [31:0] req_data = 0, pipe_inputs, pipe_outputs, rsp_data;
  logic req_valid = 0, req_ready, pipe_in_valid, pipe_flush, pipe_out_valid;
  logic rsp_valid, rsp_ready = 0, flush_req = 0, busy;
  logic drop = 0;
`ifdef PIPE_DRIVER_CHECK_EN
  logic proto_err;
`endif
  logic [31:0] pd [5];
  logic [4:0] pv = '0;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  pipeline_driver dut (
    .clk(clk), .reset(reset),
    .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .pipe_inputs(pipe_inputs), .pipe_in_valid(pipe_in_valid), .pipe_flush(pipe_flush),
    .pipe_outputs(pipe_outputs), .pipe_out_valid(pipe_out_valid),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .flush_req(flush_req), .busy(busy)
`ifdef PIPE_DRIVER_CHECK_EN
    , .proto_err(proto_err)
`endif
  );
  // each stage shifts left and sets bit 0, so 0 -> 0x1F after five stages
  always @(posedge clk) begin
    pv <= pipe_flush ? 5'b0 : {pv[3:0], pipe_in_valid};
    pd[0] <= {pipe_inputs[30:0], 1'b1};
    for (int i = 1; i < 5; i++) pd[i] <= {pd[i-1][30:0], 1'b1};
  end
  assign pipe_outputs = pd[4];
  assign pipe_out_valid = pv[4] && !drop;
  function automatic logic [31:0] f(input logic [31:0] x);
    return {x[26:0], 5'h1f};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic rv, input logic [31:0] rd, input logic rr, input logic fr);
    @(negedge clk);
    req_valid = rv;
    req_data = rd;
    rsp_ready = rr;
    flush_req = fr;
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int acc, got, nxt;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    reset = 0;
    #1;
    chk("rst_in_valid", pipe_in_valid, 0);
    chk("rst_flush", pipe_flush, 0);
    chk("rst_inputs", pipe_inputs, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);
    step(1, 0, 0, 0);
    chk("one_ready", req_ready, 1);
    chk("one_in_valid", pipe_in_valid, 1);
    chk("one_inputs", pipe_inputs, 0);
    step(0, 0, 0, 0);
    chk("one_in_valid_off", pipe_in_valid, 0);
    chk("one_busy", busy, 1);
    chk("lat_early", rsp_valid, 0);
    for (int k = 2; k <= 5; k++) begin
      step(0, 0, 0, 0);
      chk("lat_early", rsp_valid, 0);
    end
    step(0, 0, 1, 0);
    chk("lat_valid", rsp_valid, 1);
    chk("lat_data", rsp_data, 32'h1f);
    chk("lat_busy", busy, 0);
    step(0, 0, 0, 0);
    chk("lat_popped", rsp_valid, 0);
    chk("lat_popped_data", rsp_data, 0);
    acc = 0;
    nxt = 1;
    for (int c = 0; c < 20; c++) begin
      step(1, nxt, 0, 0);
      if (req_ready) begin
        acc++;
        nxt++;
      end
    end
    chk("bp_accepted", acc, 8);
    chk("bp_ready_low", req_ready, 0);
    chk("bp_count", 32'(dut.fifo_count), 8);
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 1, 0);
      chk("bp_drain_valid", rsp_valid, 1);
      chk("bp_drain_data", rsp_data, f(k + 1));
    end
    step(0, 0, 0, 0);
    chk("bp_empty", rsp_valid, 0);
    nxt = 0;
    got = 0;
    for (int c = 0; c < 200 && got < 12; c++) begin
      step(nxt < 12, 32'h100 + nxt, c[0], 0);
      if (rsp_valid && rsp_ready) begin
        chk("tog_order", rsp_data, f(32'h100 + got));
        got++;
      end
      if (req_valid && req_ready) nxt++;
    end
    chk("tog_count", got, 12);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 1, 0);
      chk("tog_no_dup", rsp_valid, 0);
    end
    chk("tog_idle", busy, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 32'h200 + i, 0, 0);
      chk("fl_issue", req_ready, 1);
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("fl_req_cycle_ready", req_ready, 0);
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0, k == 3);
      chk("fl_ready_low", req_ready, 0);
      chk("fl_flush", pipe_flush, 32'(k == 0));
      chk("fl_busy", busy, 1);
    end
    step(0, 0, 0, 0);
    chk("fl_run_ready", req_ready, 1);
    chk("fl_run_busy", busy, 0);
    chk("fl_run_flush", pipe_flush, 0);
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 1, 0);
      chk("fl_keep_valid", rsp_valid, 1);
      chk("fl_keep_data", rsp_data, f(32'h200 + k));
    end
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 1, 0);
      chk("fl_no_stale", rsp_valid, 0);
    end
    for (int i = 0; i < 7; i++) step(1, 32'h300 + i, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rs_pre_valid", rsp_valid, 1);
    chk("rs_pre_busy", busy, 1);
    chk("rs_pre_count", 32'(dut.fifo_count), 3);
    chk("rs_pre_inflight", 32'(dut.inflight), 4);
    reset = 1;
    step(0, 0, 0, 0);
    reset = 0;
    #1;
    chk("rs_valid", rsp_valid, 0);
    chk("rs_busy", busy, 0);
    chk("rs_data", rsp_data, 0);
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 1, 0);
      chk("rs_no_late", rsp_valid, 0);
    end
`ifdef PIPE_DRIVER_CHECK_EN
    chk("pe_clean", proto_err, 0);
    step(1, 32'h400, 0, 0);
    for (int k = 1; k <= 4; k++) step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    drop = 1;
    step(0, 0, 0, 0);
    drop = 0;
    chk("pe_set", proto_err, 1);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 0);
      chk("pe_held", proto_err, 1);
    end
    step(0, 0, 0, 0);
    reset = 1;
    step(0, 0, 0, 0);
    reset = 0;
    #1;
    chk("pe_cleared", proto_err, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
